// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and a
// synchronous-read instruction memory (slave). The memory registers
// mem[icache_addr] on each clock edge and returns it on icache_data.
interface instruction_fetch_unit_if;
  logic [29:0] icache_addr;
  logic [31:0] icache_data;

  modport master (output icache_addr, input  icache_data);
  modport slave  (input  icache_addr, output icache_data);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the word address of a
// one-cycle-latency instruction memory from next-PC so sequential fetch has
// no bubbles, and presents pc/instruction/valid/fault to decode. Handles
// decode stalls, branch/jump redirects and misaligned redirect targets.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined;
// otherwise fetch_cnt/bubble_cnt read as zero and no counter flops exist.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          IMEM_WORDS_LOG2 = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_en,
  input  logic [31:0]          redirect_pc,
  instruction_fetch_unit_if.master imem,
  output logic [31:0]          pc_out,
  output logic [31:0]          inst_out,
  output logic                 valid_out,
  output logic                 fault_out,
  output logic                 misalign_err,
  output logic [31:0]          fetch_cnt,
  output logic [31:0]          bubble_cnt
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} st_e;

  st_e         st_q, st_d;
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;

  // Next-PC select and FSM next state. The same npc feeds the memory address,
  // so the word latched at this edge is the one presented next cycle.
  always_comb begin
    pc_d = pc_q + 32'd4;
    st_d = RUN;
    if (rst) begin
      pc_d = RESET_PC;
      st_d = BOOT;
    end else if (redirect_en) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (st_q == BOOT || stall) begin
      pc_d = pc_q;
    end
  end

  // Misaligned redirect flag: low bits are dropped, the event is remembered.
  always_comb begin
    misalign_d = misalign_q | (redirect_en & (|redirect_pc[1:0]));
    if (rst) misalign_d = 1'b0;
  end

  // Fetch PC, state and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      st_q       <= BOOT;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      st_q       <= st_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem.icache_addr = pc_d[31:2];
  assign pc_out           = pc_q;
  assign inst_out         = imem.icache_data;
  assign valid_out        = (st_q == RUN);
  assign misalign_err     = misalign_q;
  // Anything above the memory's byte range is a fault; the memory reads 0 there.
  assign fault_out        = valid_out & ((pc_q >> (IMEM_WORDS_LOG2 + 2)) != 32'd0);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Accepted-instruction and bubble counters, wrapping modulo 2^32.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (valid_out && !stall) fetch_cnt_d  = fetch_cnt_q + 32'd1;
    if (!valid_out)          bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign fetch_cnt  = 32'h0;
  assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 4K-word synchronous
// memory model preloaded with word i = 32'h1000_0000 + i.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, stall, redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out, inst_out, fetch_cnt, bubble_cnt;
  logic        valid_out, fault_out, misalign_err;
  int          errs = 0;
  int          checks = 0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS_LOG2(12)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem(bus.master), .pc_out(pc_out),
    .inst_out(inst_out), .valid_out(valid_out), .fault_out(fault_out),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // memory model: one-cycle registered read, zero outside 4K words
  always @(posedge clk)
    bus.icache_data <= (bus.icache_addr < 30'd4096) ? (32'h1000_0000 + {2'b00, bus.icache_addr}) : 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // hold reset two edges, release; returns in cycle 1 (BOOT)
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk("reset_valid", {31'b0, valid_out}, 32'd0);
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_fault", {31'b0, fault_out}, 32'd0);
    chk("reset_misalign", {31'b0, misalign_err}, 32'd0);
    chk("reset_fetch_cnt", fetch_cnt, 32'd0);
    chk("reset_bubble_cnt", bubble_cnt, 32'd0);
  endtask

  task automatic test_sequential();
    step();
    chk("c2_pc", pc_out, 32'h0);
    chk("c2_inst", inst_out, 32'h1000_0000);
    chk("c2_valid", {31'b0, valid_out}, 32'd1);
    step();
    chk("c3_pc", pc_out, 32'h4);
    chk("c3_inst", inst_out, 32'h1000_0001);
    chk("c3_addr", {2'b00, bus.icache_addr}, 32'd2);
    step();
    chk("c4_pc", pc_out, 32'h8);
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_pc", pc_out, 32'h8);
      chk("stall_inst", inst_out, 32'h1000_0002);
      chk("stall_valid", {31'b0, valid_out}, 32'd1);
      if (i < 2) step();
    end
    chk("stall_addr", {2'b00, bus.icache_addr}, 32'd2);
    step();
    stall = 1'b0;
    step();
    chk("post_stall_pc", pc_out, 32'hC);
    chk("post_stall_inst", inst_out, 32'h1000_0003);
  endtask

  task automatic test_redirect();
    redirect_en = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    redirect_en = 1'b0; stall = 1'b0;
    chk("redir_pc", pc_out, 32'h40);
    chk("redir_inst", inst_out, 32'h1000_0010);
    chk("redir_valid", {31'b0, valid_out}, 32'd1);
    chk("redir_misalign", {31'b0, misalign_err}, 32'd0);
  endtask

  task automatic test_misalign();
    redirect_en = 1'b1; redirect_pc = 32'h22;
    step();
    redirect_en = 1'b0;
    chk("mis_pc", pc_out, 32'h20);
    chk("mis_inst", inst_out, 32'h1000_0008);
    chk("mis_flag", {31'b0, misalign_err}, 32'd1);
    step();
    chk("mis_next_pc", pc_out, 32'h24);
    chk("mis_sticky", {31'b0, misalign_err}, 32'd1);
  endtask

  task automatic test_fault();
    redirect_en = 1'b1; redirect_pc = 32'h4000;
    step();
    chk("fault_pc", pc_out, 32'h4000);
    chk("fault_flag", {31'b0, fault_out}, 32'd1);
    chk("fault_valid", {31'b0, valid_out}, 32'd1);
    chk("fault_inst", inst_out, 32'h0);
    redirect_pc = 32'h3FFC;
    step();
    redirect_en = 1'b0;
    chk("edge_pc", pc_out, 32'h3FFC);
    chk("edge_fault", {31'b0, fault_out}, 32'd0);
    chk("edge_inst", inst_out, 32'h1000_0FFF);
    step();
    chk("over_pc", pc_out, 32'h4000);
    chk("over_fault", {31'b0, fault_out}, 32'd1);
    chk("misalign_still", {31'b0, misalign_err}, 32'd1);
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h100;
    step();
    rst = 1'b0; stall = 1'b0; redirect_en = 1'b0;
    chk("mid_rst_valid", {31'b0, valid_out}, 32'd0);
    chk("mid_rst_pc", pc_out, 32'h0);
    chk("mid_rst_misalign", {31'b0, misalign_err}, 32'd0);
    chk("mid_rst_fault", {31'b0, fault_out}, 32'd0);
  endtask

  task automatic test_boot_redirect();
    // in BOOT now: redirect is taken and next cycle is RUN at the target
    redirect_en = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_en = 1'b0;
    chk("boot_redir_pc", pc_out, 32'h80);
    chk("boot_redir_valid", {31'b0, valid_out}, 32'd1);
    chk("boot_redir_inst", inst_out, 32'h1000_0020);
  endtask

  task automatic test_boot_stall();
    do_reset();
    stall = 1'b1;
    step();
    chk("boot_stall_valid", {31'b0, valid_out}, 32'd1);
    chk("boot_stall_pc", pc_out, 32'h0);
    stall = 1'b0;
  endtask

  task automatic test_perf_counters();
    logic [31:0] exp_fetch, exp_bubble;
`ifdef FETCH_PERF_CNT_EN
    exp_fetch = 32'd7; exp_bubble = 32'd1;
`else
    exp_fetch = 32'd0; exp_bubble = 32'd0;
`endif
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      stall = (c == 4 || c == 5);
      step();
    end
    stall = 1'b0;
    chk("perf_fetch_cnt", fetch_cnt, exp_fetch);
    chk("perf_bubble_cnt", bubble_cnt, exp_bubble);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("perf_rst_fetch", fetch_cnt, 32'd0);
    chk("perf_rst_bubble", bubble_cnt, 32'd0);
    chk("perf_rst_boot", {31'b0, valid_out}, 32'd0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_fault();
    test_mid_reset();
    test_boot_redirect();
    test_boot_stall();
    test_perf_counters();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
